// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Boot-time program loader. Takes a byte stream over valid/ready,
//               assembles little-endian words and writes them to consecutive
//               main-memory addresses from 0. The CPU is held in reset until
//               the complete image has been written.
//               Supports ADDR_WIDTH up to 15, so that the 16-bit header count
//               can be range-checked against the memory depth.
// Revision    : 1.0  initial release
// ============================================================================
module mem_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_load,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int c_BPW  = DATA_WIDTH / 8;
    localparam int c_IDXW = (c_BPW > 1) ? $clog2(c_BPW) : 1;
    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(c_BPW - 1);
    localparam logic [16:0]       c_DEPTH    = 17'd1 << ADDR_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_HDR0  = 4'd1,
        S_HDR1  = 4'd2,
        S_BYTE  = 4'd3,
        S_SETUP = 4'd4,
        S_WRITE = 4'd5,
        S_HOLD  = 4'd6,
        S_DONE  = 4'd7,
        S_ERROR = 4'd8
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [7:0]            r_hdr_lo;
    logic [ADDR_WIDTH:0]   r_num_words;
    logic [ADDR_WIDTH:0]   r_word_cnt;
    logic [c_IDXW-1:0]     r_idx;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_data;
    logic                  r_rx_ready;
    logic                  r_ram_load;
    logic                  r_cpu_rst_n;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic                  w_xfer;
    logic [15:0]           w_hdr_n;
    logic                  w_hdr_zero;
    logic                  w_hdr_big;
    logic                  w_last_byte;
    logic [ADDR_WIDTH:0]   w_cnt_inc;
    logic                  w_nxt_rx_ready;
    logic                  w_nxt_ram_load;
    logic                  w_nxt_cpu_rst_n;
    logic                  w_nxt_busy;
    logic                  w_nxt_done;
    logic                  w_nxt_error;

    assign w_xfer      = rx_valid & r_rx_ready;
    assign w_hdr_n     = {rx_data, r_hdr_lo};
    assign w_hdr_zero  = (w_hdr_n == 16'd0);
    assign w_hdr_big   = ({1'b0, w_hdr_n} > c_DEPTH);
    assign w_last_byte = (r_idx == c_LAST_IDX);
    assign w_cnt_inc   = r_word_cnt + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they can be registered
    always_comb begin
        w_next_state    = r_state;
        w_nxt_rx_ready  = 1'b0;
        w_nxt_ram_load  = 1'b0;
        w_nxt_cpu_rst_n = 1'b0;
        w_nxt_busy      = 1'b0;
        w_nxt_done      = 1'b0;
        w_nxt_error     = 1'b0;

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) w_next_state = S_HDR0;
            end
            S_HDR0: begin
                if (w_xfer) w_next_state = S_HDR1;
            end
            S_HDR1: begin
                if (w_xfer) begin
                    if (w_hdr_zero)     w_next_state = S_DONE;
                    else if (w_hdr_big) w_next_state = S_ERROR;
                    else                w_next_state = S_BYTE;
                end
            end
            S_BYTE: begin
                if (w_xfer && w_last_byte) w_next_state = S_SETUP;
            end
            S_SETUP: w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_HOLD;
            S_HOLD: begin
                if (w_cnt_inc == r_num_words) w_next_state = S_DONE;
                else                          w_next_state = S_BYTE;
            end
            default: w_next_state = S_IDLE;
        endcase

        case (w_next_state)
            S_HDR0, S_HDR1, S_BYTE: begin
                w_nxt_rx_ready = 1'b1;
                w_nxt_busy     = 1'b1;
            end
            S_SETUP, S_HOLD: w_nxt_busy = 1'b1;
            S_WRITE: begin
                w_nxt_busy     = 1'b1;
                w_nxt_ram_load = 1'b1;
            end
            S_DONE: begin
                w_nxt_done      = 1'b1;
                w_nxt_cpu_rst_n = 1'b1;
            end
            S_ERROR: w_nxt_error = 1'b1;
            default: ;
        endcase
    end

    // Header capture, word assembly and address/counter bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr_lo    <= '0;
            r_num_words <= '0;
            r_word_cnt  <= '0;
            r_idx       <= '0;
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
        end else begin
            case (r_state)
                S_HDR0: begin
                    if (w_xfer) r_hdr_lo <= rx_data;
                end
                S_HDR1: begin
                    if (w_xfer) begin
                        // Truncation only matters for oversize counts, which go to ERROR
                        r_num_words <= w_hdr_n[ADDR_WIDTH:0];
                        r_word_cnt  <= '0;
                        r_idx       <= '0;
                    end
                end
                S_BYTE: begin
                    if (w_xfer) begin
                        r_ram_data[{r_idx, 3'b000} +: 8] <= rx_data;
                        if (w_last_byte) begin
                            r_idx      <= '0;
                            // Address is presented together with the finished word in SETUP
                            r_ram_addr <= r_word_cnt[ADDR_WIDTH-1:0];
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_HOLD: r_word_cnt <= w_cnt_inc;
                default: ;
            endcase
        end
    end

    // Registered status and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ready  <= 1'b0;
            r_ram_load  <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_rx_ready  <= w_nxt_rx_ready;
            r_ram_load  <= w_nxt_ram_load;
            r_cpu_rst_n <= w_nxt_cpu_rst_n;
            r_busy      <= w_nxt_busy;
            r_done      <= w_nxt_done;
            r_error     <= w_nxt_error;
        end
    end

    assign rx_ready  = r_rx_ready;
    assign ram_addr  = r_ram_addr;
    assign ram_data  = r_ram_data;
    assign ram_load  = r_ram_load;
    assign cpu_rst_n = r_cpu_rst_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;

endmodule
`default_nettype wire
